// File: rtl/craft_decrypt_if.sv
// rtl/craft_decrypt_if.sv - start/done request and result bundle for the CRAFT-64 decryption core
interface craft_decrypt_if;
  logic         start;
  logic [63:0]  ciphertext;
  logic [63:0]  tweak;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [63:0]  plaintext;

  modport master (
    output start, ciphertext, tweak, key,
    input  busy, done, plaintext
  );

  modport slave (
    input  start, ciphertext, tweak, key,
    output busy, done, plaintext
  );
endinterface

// File: rtl/craft_decrypt.sv
// rtl/craft_decrypt.sv - iterative CRAFT-64 decryption core, one inverse round per clock
module craft_decrypt #(
  parameter int ROUNDS = 32
) (
  input  logic           clk,
  input  logic           rst,
  craft_decrypt_if.slave bus
);

  if (ROUNDS != 32) begin : g_rounds_check
    $error("craft_decrypt: only ROUNDS=32 is supported");
  end

  typedef enum logic [1:0] {IDLE, FIRST, ROUND, DONE} fsm_t;

  localparam logic [3:0] SBOX [16] = '{4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
                                       4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
  // The encrypt nibble permutation happens to be its own inverse, so this table serves both ways.
  localparam int PN_INV [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  localparam int Q_PERM [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  function automatic logic [63:0] sub_nibbles(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[63-4*j -: 4] = SBOX[x[63-4*j -: 4]];
    return r;
  endfunction

  function automatic logic [63:0] pn_inverse(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[63-4*j -: 4] = x[63-4*PN_INV[j] -: 4];
    return r;
  endfunction

  function automatic logic [63:0] q_perm(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[63-4*j -: 4] = x[63-4*Q_PERM[j] -: 4];
    return r;
  endfunction

  function automatic logic [63:0] mix_columns(input logic [63:0] x);
    logic [63:0] r;
    r = x;
    for (int c = 0; c < 4; c++) begin
      r[63-4*c -: 4]     = x[63-4*c -: 4] ^ x[63-4*(8+c) -: 4] ^ x[63-4*(12+c) -: 4];
      r[63-4*(4+c) -: 4] = x[63-4*(4+c) -: 4] ^ x[63-4*(12+c) -: 4];
    end
    return r;
  endfunction

  // {a_i, 0, b_i} per round, unrolled from the encrypt-side LFSRs.
  function automatic logic [63:0] add_round_const(input logic [63:0] x, input logic [4:0] idx);
    logic [7:0] rc;
    rc = '0;
    case (idx)
      5'd0:  rc = 8'h11;  5'd1:  rc = 8'h84;  5'd2:  rc = 8'h42;  5'd3:  rc = 8'h25;
      5'd4:  rc = 8'h96;  5'd5:  rc = 8'hc7;  5'd6:  rc = 8'h63;  5'd7:  rc = 8'hb1;
      5'd8:  rc = 8'h54;  5'd9:  rc = 8'ha2;  5'd10: rc = 8'hd5;  5'd11: rc = 8'he6;
      5'd12: rc = 8'hf7;  5'd13: rc = 8'h73;  5'd14: rc = 8'h31;  5'd15: rc = 8'h14;
      5'd16: rc = 8'h82;  5'd17: rc = 8'h45;  5'd18: rc = 8'h26;  5'd19: rc = 8'h97;
      5'd20: rc = 8'hc3;  5'd21: rc = 8'h61;  5'd22: rc = 8'hb4;  5'd23: rc = 8'h52;
      5'd24: rc = 8'ha5;  5'd25: rc = 8'hd6;  5'd26: rc = 8'he7;  5'd27: rc = 8'hf3;
      5'd28: rc = 8'h71;  5'd29: rc = 8'h34;  5'd30: rc = 8'h12;  5'd31: rc = 8'h85;
      default: rc = 8'h00;
    endcase
    return x ^ {16'h0000, rc, 40'h00_0000_0000};
  endfunction

  fsm_t         fsm;
  logic [4:0]   rc_idx;
  logic [63:0]  st;
  logic [63:0]  t_q;
  logic [127:0] k_q;
  logic         busy_q;
  logic         done_q;
  logic [63:0]  pt_q;

  logic [63:0]  tq_perm;
  logic [63:0]  tk_sel;
  logic [63:0]  round_in;
  logic [63:0]  round_out;

  // FIRST undoes the encrypt final round, which has no S-box or permutation layer.
  always_comb begin
    tq_perm = q_perm(t_q);
    case (rc_idx[1:0])
      2'd0:    tk_sel = k_q[127:64] ^ t_q;
      2'd1:    tk_sel = k_q[63:0]   ^ t_q;
      2'd2:    tk_sel = k_q[127:64] ^ tq_perm;
      default: tk_sel = k_q[63:0]   ^ tq_perm;
    endcase
    round_in  = (fsm == FIRST) ? st : pn_inverse(sub_nibbles(st));
    round_out = mix_columns(add_round_const(round_in ^ tk_sel, rc_idx));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm    <= IDLE;
      rc_idx <= '0;
      st     <= '0;
      t_q    <= '0;
      k_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pt_q   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            st     <= bus.ciphertext;
            t_q    <= bus.tweak;
            k_q    <= bus.key;
            rc_idx <= 5'd31;
            busy_q <= 1'b1;
            fsm    <= FIRST;
          end
        end
        FIRST: begin
          st     <= round_out;
          rc_idx <= rc_idx - 5'd1;
          fsm    <= ROUND;
        end
        ROUND: begin
          st <= round_out;
          if (rc_idx == 5'd0) begin
            pt_q   <= round_out;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            fsm    <= DONE;
          end else begin
            rc_idx <= rc_idx - 5'd1;
          end
        end
        default: begin
          done_q <= 1'b0;
          fsm    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.plaintext = pt_q;

endmodule
